keypad_scan_debounce: RTL and testbench

- Upstream stage of the shower-controller state machine. Drives the 4x4 membrane keypad columns and reads its rows.
- Debounces each press and encodes it to the 4-bit key code the controller consumes on `num`.
- Emits a one-cycle `key_valid` strobe per physical press, so downstream states no longer need to guard against the same key being read repeatedly.

---
 rtl/keypad_scan_debounce.sv | 149 ++++++++++++++
 tb/tb_keypad_scan_debounce.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_debounce.sv
// rtl/keypad_scan_debounce.sv - 4x4 keypad column scanner with press/release debounce and key encoding
module keypad_scan_debounce #(
  parameter int SCAN_TICKS     = 50_000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [3:0] filas,
  output logic [3:0] column,
  output logic [3:0] num,
  output logic       key_valid,
  output logic       key_held
);

  localparam int TW = $clog2(SCAN_TICKS);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [DW-1:0] DEB_DONE  = DW'(DEBOUNCE_SCANS);

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_HELD     = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  logic [3:0]    sync1;
  logic [3:0]    rows;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [1:0]    state;
  logic [1:0]    col_idx;
  logic [1:0]    row_idx;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] deb_next;
  logic          sample_valid;
  logic [1:0]    sample_row;
  logic          rows_idle;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_code = 4'h1;
      4'h1: key_code = 4'h2;
      4'h2: key_code = 4'h3;
      4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;
      4'h5: key_code = 4'h5;
      4'h6: key_code = 4'h6;
      4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;
      4'h9: key_code = 4'h8;
      4'hA: key_code = 4'h9;
      4'hB: key_code = 4'hC;
      4'hC: key_code = 4'hF;
      4'hD: key_code = 4'h0;
      4'hE: key_code = 4'hE;
      default: key_code = 4'hD;
    endcase
  endfunction

  assign tick      = (tick_cnt == TICK_LAST);
  assign deb_next  = deb_cnt + DW'(1);
  assign rows_idle = (rows == 4'b1111);
  assign column    = ~(4'b0001 << col_idx);

  // Multiple low rows are ambiguous and deliberately read as no key.
  always_comb begin
    sample_valid = 1'b0;
    sample_row   = 2'd0;
    case (rows)
      4'b1110: begin sample_valid = 1'b1; sample_row = 2'd0; end
      4'b1101: begin sample_valid = 1'b1; sample_row = 2'd1; end
      4'b1011: begin sample_valid = 1'b1; sample_row = 2'd2; end
      4'b0111: begin sample_valid = 1'b1; sample_row = 2'd3; end
      default: begin sample_valid = 1'b0; sample_row = 2'd0; end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      sync1     <= 4'b1111;
      rows      <= 4'b1111;
      tick_cnt  <= '0;
      state     <= S_SCAN;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      deb_cnt   <= '0;
      num       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      sync1     <= filas;
      rows      <= sync1;
      tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          S_SCAN: begin
            if (sample_valid) begin
              row_idx <= sample_row;
              deb_cnt <= DW'(1);
              state   <= S_DEBOUNCE;
            end else begin
              col_idx <= col_idx + 2'd1;
            end
          end
          S_DEBOUNCE: begin
            if (sample_valid && (sample_row == row_idx)) begin
              if (deb_next == DEB_DONE) begin
                num       <= key_code(row_idx, col_idx);
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                deb_cnt   <= '0;
                state     <= S_HELD;
              end else begin
                deb_cnt <= deb_next;
              end
            end else begin
              deb_cnt <= '0;
              col_idx <= col_idx + 2'd1;
              state   <= S_SCAN;
            end
          end
          // Extra keys in the frozen column keep us here; only all-high starts a release.
          S_HELD: begin
            if (rows_idle) begin
              deb_cnt <= DW'(1);
              state   <= S_RELEASE;
            end
          end
          default: begin
            if (rows_idle) begin
              if (deb_next == DEB_DONE) begin
                key_held <= 1'b0;
                deb_cnt  <= '0;
                col_idx  <= col_idx + 2'd1;
                state    <= S_SCAN;
              end else begin
                deb_cnt <= deb_next;
              end
            end else begin
              deb_cnt <= '0;
              state   <= S_HELD;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// tb/tb_keypad_scan_debounce.sv - directed bench for keypad_scan_debounce with a membrane keypad model
module tb_keypad_scan_debounce;

  logic        Clk;
  logic        reset;
  logic [3:0]  filas;
  logic [3:0]  column;
  logic [3:0]  num;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys;
  int          vec_count = 0;
  int          miscompares = 0;
  int          kv_total = 0;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  column;
    logic [3:0]  num;
    logic        kv;
    logic        held;
  } vec_t;

  keypad_scan_debounce #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(3)) dut (
    .Clk(Clk),
    .reset(reset),
    .filas(filas),
    .column(column),
    .num(num),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Key (r,c) is bit r*4+c; it pulls row r low while column c is driven low.
  always_comb begin
    filas = 4'b1111;
    for (int r = 0; r < 4; r++)
      filas[r] = ~|(keys[r*4 +: 4] & ~column);
  end

  always @(posedge Clk) begin
    #1;
    if (key_valid) kv_total = kv_total + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_kv(input string name, input int budget);
    int start;
    int n;
    start = kv_total;
    n = 0;
    while (kv_total == start && n < budget) begin
      @(negedge Clk);
      n++;
    end
    if (kv_total == start) begin
      miscompares++;
      vec_count++;
      $display("FAIL %s: no key_valid within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_release(input string name, input int budget);
    int n;
    n = 0;
    while (key_held && n < budget) begin
      @(negedge Clk);
      n++;
    end
    if (key_held) begin
      miscompares++;
      vec_count++;
      $display("FAIL %s: key_held still 1 after %0d cycles", name, budget);
    end
  endtask

  task automatic wait_col_enter(input logic [3:0] target, input int budget);
    int n;
    n = 0;
    while (column == target && n < budget) begin @(negedge Clk); n++; end
    while (column != target && n < budget) begin @(negedge Clk); n++; end
    if (column != target) begin
      miscompares++;
      vec_count++;
      $display("FAIL wait_col: column %b never reached %b", column, target);
    end
  endtask

  vec_t vecs[17];

  initial begin
    int base;
    int lat;
    logic [3:0] cols_seen;

    for (int i = 0; i < 17; i++) begin
      vecs[i].keys   = 16'h0000;
      vecs[i].column = (i < 4) ? 4'b1110 : (i < 8) ? 4'b1101 : (i < 12) ? 4'b1011 :
                       (i < 16) ? 4'b0111 : 4'b1110;
      vecs[i].num    = 4'h0;
      vecs[i].kv     = 1'b0;
      vecs[i].held   = 1'b0;
    end

    keys  = 16'h0000;
    reset = 1'b1;
    repeat (3) @(negedge Clk);
    reset = 1'b0;

    // Idle scan after reset.
    for (int i = 0; i < 17; i++) begin
      keys = vecs[i].keys;
      check($sformatf("idle_vec%0d", i), {column, num, key_valid, key_held},
            {vecs[i].column, vecs[i].num, vecs[i].kv, vecs[i].held});
      @(negedge Clk);
    end

    // Key 'A' in column 3, held 40 cycles: single strobe, then clean release.
    base = kv_total;
    keys = 16'h0008;
    wait_kv("press_A", 200);
    check("A_num", num, 4'hA);
    check("A_held", key_held, 1'b1);
    repeat (40) @(negedge Clk);
    check("A_single_strobe", kv_total - base, 1);
    check("A_still_held", key_held, 1'b1);
    keys = 16'h0000;
    wait_release("A_release", 40);
    check("A_col_wrap", column, 4'b1110);
    repeat (4) @(negedge Clk);
    check("A_scan_resumes", column, 4'b1101);

    // '*' then '#' with full release in between.
    base = kv_total;
    keys = 16'h1000;
    wait_kv("press_star", 200);
    check("star_num", num, 4'hF);
    keys = 16'h0000;
    wait_release("star_release", 60);
    keys = 16'h4000;
    wait_kv("press_hash", 200);
    check("hash_num", num, 4'hE);
    keys = 16'h0000;
    wait_release("hash_release", 60);
    check("star_hash_strobes", kv_total - base, 2);

    // Bounce on key '5': two good ticks, one open tick, then stable.
    wait_col_enter(4'b1101, 100);
    base = kv_total;
    keys = 16'h0020;
    repeat (8) @(negedge Clk);
    keys = 16'h0000;
    repeat (4) @(negedge Clk);
    check("bounce_no_strobe", kv_total - base, 0);
    check("bounce_col_rotated", column, 4'b1011);
    keys = 16'h0020;
    lat = 0;
    while (!key_valid && lat < 100) begin @(negedge Clk); lat++; end
    check("bounce_latency", lat, 24);
    check("bounce_num", num, 4'h5);
    check("bounce_strobes", kv_total - base, 1);
    keys = 16'h0000;
    wait_release("bounce_release", 60);

    // Two rows low in column 0: ignored, scan keeps rotating.
    base = kv_total;
    keys = 16'h0101;
    cols_seen = 4'b0000;
    for (int i = 0; i < 64; i++) begin
      @(negedge Clk);
      cols_seen = cols_seen | ~column;
    end
    check("multi_no_strobe", kv_total - base, 0);
    check("multi_num_kept", num, 4'h5);
    check("multi_not_held", key_held, 1'b0);
    check("multi_rotation", cols_seen, 4'b1111);
    keys = 16'h0000;
    repeat (8) @(negedge Clk);

    // Reset while HELD, key '6' still pressed: full re-debounce required.
    keys = 16'h0040;
    wait_kv("press_6", 200);
    check("six_num", num, 4'h6);
    repeat (6) @(negedge Clk);
    check("six_held", key_held, 1'b1);
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    check("reset_outputs", {column, num, key_valid, key_held}, {4'b1110, 4'h0, 1'b0, 1'b0});
    lat = 0;
    while (!key_valid && lat < 100) begin @(negedge Clk); lat++; end
    check("redebounce_latency", lat, 20);
    check("redebounce_num", num, 4'h6);
    check("redebounce_held", key_held, 1'b1);
    keys = 16'h0000;
    wait_release("six_release", 60);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
